// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and sizing helper for the PISO transmitter
package piso_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  function automatic int cnt_width(int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/piso_shift_core.sv
// piso_shift_core: loadable shift register whose direction is latched with the word
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_msb,
  input  logic             shift_en,
  output logic             head
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             msb_q, msb_d;
  always_comb begin
    msb_d   = load ? load_msb : msb_q;
    shreg_d = load ? load_data : shift_en ? (msb_q ? shreg_q << 1 : shreg_q >> 1) : shreg_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      msb_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      msb_q   <= msb_d;
    end
  end
  assign head = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/piso_serial_transmitter.sv
// piso_serial_transmitter: valid/ready word loader feeding a one-bit-per-beat serial stream
module piso_serial_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             msb_first,
  output logic             serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            serial_valid_q, serial_valid_d;
  logic            last_beat, accept, shift_en;
  // With no gap, the last beat reopens the load window so words stream without a bubble
  always_comb begin
    last_beat      = state_q == SHIFT && serial_ready && bit_cnt_q == LAST;
    load_ready     = !reset && (state_q == IDLE || (GAP_CYCLES == 0 && last_beat));
    accept         = load_valid && load_ready;
    shift_en       = state_q == SHIFT && serial_ready && !accept;
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    if (accept) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
    end else if (last_beat) begin
      state_d   = GAP_CYCLES > 0 ? GAP : IDLE;
      gap_cnt_d = '0;
    end else if (shift_en) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end else if (state_q == GAP) begin
      state_d   = gap_cnt_q == GAP_LAST ? IDLE : GAP;
      gap_cnt_d = gap_cnt_q + 1'b1;
    end
    serial_valid_d = state_d == SHIFT;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      serial_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      serial_valid_q <= serial_valid_d;
    end
  end
  piso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_data (load_data),
    .load_msb  (msb_first),
    .shift_en  (shift_en),
    .head      (serial_out)
  );
  assign serial_valid = serial_valid_q;
  assign frame_start  = serial_valid_q && bit_cnt_q == '0;
  assign frame_last   = serial_valid_q && bit_cnt_q == LAST;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_piso_serial_transmitter.sv
// tb_piso_serial_transmitter: directed vectors on a no-gap and a two-cycle-gap transmitter
module tb_piso_serial_transmitter;
  logic       clk = 1'b0;
  logic       reset, load_valid, msb_first, serial_ready;
  logic [3:0] load_data;
  logic       m_rdy, m_out, m_vld, m_st, m_lst, m_bsy;
  logic       g_rdy, g_out, g_vld, g_st, g_lst, g_bsy;
  int         n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  piso_serial_transmitter #(.WIDTH(4), .GAP_CYCLES(0)) dut_m (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_rdy), .msb_first(msb_first), .serial_out(m_out),
    .serial_valid(m_vld), .serial_ready(serial_ready), .frame_start(m_st),
    .frame_last(m_lst), .busy(m_bsy)
  );

  piso_serial_transmitter #(.WIDTH(4), .GAP_CYCLES(2)) dut_g (
    .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
    .load_ready(g_rdy), .msb_first(msb_first), .serial_out(g_out),
    .serial_valid(g_vld), .serial_ready(serial_ready), .frame_start(g_st),
    .frame_last(g_lst), .busy(g_bsy)
  );

  typedef struct {
    logic       sel, rst, ld;
    logic [3:0] data;
    logic       msb, srdy, chk, out, vld, st, lst, rdy, bsy;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(int sel, int rst, int ld, int data, int msb, int srdy,
                             int chk, int out, int vld, int st, int lst, int rdy, int bsy);
    return '{1'(sel), 1'(rst), 1'(ld), 4'(data), 1'(msb), 1'(srdy),
             1'(chk), 1'(out), 1'(vld), 1'(st), 1'(lst), 1'(rdy), 1'(bsy)};
  endfunction

  task automatic check(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checkw(string nm, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t       r;
    logic [3:0] got;
    int         nb;
    logic       done, first_st;
    // columns: sel rst ld data msb srdy | chk out vld st lst rdy bsy
    vecs.push_back(v(0,1,0,4'h0,0,1, 1,0,0,0,0,0,0));
    // LSB-first 1011 -> 1,1,0,1
    vecs.push_back(v(0,0,1,4'hB,0,1, 1,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,1,1,1));
    // MSB-first 1011 -> 1,0,1,1 with msb_first wiggling mid-frame
    vecs.push_back(v(0,0,1,4'hB,1,1, 0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,1,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,1,1, 1,1,1,0,1,1,1));
    // back-to-back A then 5 -> 0,1,0,1,1,0,1,0
    vecs.push_back(v(0,0,1,4'hA,0,1, 0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,1,4'h5,0,1, 1,0,1,1,0,0,1));
    vecs.push_back(v(0,0,1,4'h5,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,1,4'h5,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(0,0,1,4'h5,0,1, 1,1,1,0,1,1,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,1,1,1));
    // 0110 with a 3-cycle stall on bit 2 and a stall on the last bit
    vecs.push_back(v(0,0,1,4'h6,0,1, 0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,0, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,0, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,1,4'h9,0,0, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,1,4'h9,0,0, 1,0,1,0,1,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,1,1,1));
    // reset after two bits of F, then 3 -> 1,1,0,0
    vecs.push_back(v(0,0,1,4'hF,0,1, 0,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,1,1,4'h3,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,1,4'h3,0,1, 1,0,0,0,0,1,0));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(0,0,0,4'h0,0,1, 1,0,1,0,1,1,1));
    vecs.push_back(v(0,1,0,4'h0,0,1, 1,0,0,0,0,0,0));
    // two-cycle gap: 9 then queued 6
    vecs.push_back(v(1,1,0,4'h0,0,1, 1,0,0,0,0,0,0));
    vecs.push_back(v(1,0,1,4'h9,0,1, 1,0,0,0,0,1,0));
    vecs.push_back(v(1,0,1,4'h6,0,1, 1,1,1,1,0,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 1,0,1,0,0,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 1,1,1,0,1,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 0,0,0,0,0,0,1));
    vecs.push_back(v(1,0,1,4'h6,0,1, 0,0,0,0,0,1,0));
    vecs.push_back(v(1,0,0,4'h0,0,1, 1,0,1,1,0,0,1));
    vecs.push_back(v(1,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(1,0,0,4'h0,0,1, 1,1,1,0,0,0,1));
    vecs.push_back(v(1,0,0,4'h0,0,1, 1,0,1,0,1,0,1));
    vecs.push_back(v(1,0,0,4'h0,0,1, 0,0,0,0,0,0,1));

    reset = 1'b1; load_valid = 1'b0; load_data = '0; msb_first = 1'b0; serial_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      r = vecs[i];
      reset = r.rst; load_valid = r.ld; load_data = r.data;
      msb_first = r.msb; serial_ready = r.srdy;
      @(negedge clk);
      if (r.chk) check($sformatf("v%0d_out", i), r.sel ? g_out : m_out, r.out);
      check($sformatf("v%0d_valid", i), r.sel ? g_vld : m_vld, r.vld);
      check($sformatf("v%0d_start", i), r.sel ? g_st : m_st, r.st);
      check($sformatf("v%0d_last", i), r.sel ? g_lst : m_lst, r.lst);
      check($sformatf("v%0d_ready", i), r.sel ? g_rdy : m_rdy, r.rdy);
      check($sformatf("v%0d_busy", i), r.sel ? g_bsy : m_bsy, r.bsy);
      @(posedge clk);
      #1;
    end

    // MSB-first C under alternating backpressure; rebuild the word from accepted beats
    reset = 1'b1; load_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; load_valid = 1'b1; load_data = 4'hC; msb_first = 1'b1; serial_ready = 1'b1;
    @(posedge clk);
    #1;
    load_valid = 1'b0; msb_first = 1'b0;
    got = '0; nb = 0; done = 1'b0; first_st = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      serial_ready = c[0];
      @(negedge clk);
      if (m_vld && serial_ready) begin
        if (nb == 0) first_st = m_st;
        got = {got[2:0], m_out};
        nb++;
        if (m_lst) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    check("hs_done", done, 1'b1);
    check("hs_first_start", first_st, 1'b1);
    checkw("hs_word", got, 4'hC);
    checkw("hs_bits", 4'(nb), 4'd4);
    @(negedge clk);
    check("hs_idle_valid", m_vld, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
